// File: rtl/gate_response_misr.sv
// gate_response_misr: response compactor for the 12-in/10-out gate-level test
// netlist. Each accepted beat is folded into a Galois MISR. After NUM_PATTERNS
// beats the final signature is compared with `golden` and reported on pass/done.
//
// Optional feature macro: GATE_RESPONSE_MISR_XMASK_EN
//   Adds resp_mask (masked bits compact as 0) and x_seen (an unmasked X/Z bit
//   was accepted since the last start/reset).
//
// Handshake: a beat transfers on a rising clk edge where resp_valid && resp_ready.
// resp_ready depends only on the FSM state (high in RUN), never on resp_valid.
// The producer may hold resp_valid low for any number of cycles.
module gate_response_misr #(
  parameter int               WIDTH        = 10,
  parameter int               NUM_PATTERNS = 256,
  parameter logic [WIDTH-1:0] POLY         = 10'h009,
  parameter logic [WIDTH-1:0] SEED         = 10'h000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             resp_valid,
  output logic             resp_ready,
  input  logic [WIDTH-1:0] resp,
`ifdef GATE_RESPONSE_MISR_XMASK_EN
  input  logic [WIDTH-1:0] resp_mask,
  output logic             x_seen,
`endif
  input  logic [WIDTH-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [15:0]      beat_count,
  output logic [1:0]       fsm_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Beat index that completes a run.
  localparam logic [15:0] LAST_BEAT = 16'(NUM_PATTERNS - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] sig_q;
  logic [15:0]      cnt_q;
  logic             pass_q;
  logic             accept;
  logic             last_beat;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] sig_next;
  logic [15:0]      cnt_inc;

`ifdef GATE_RESPONSE_MISR_XMASK_EN
  logic x_seen_q;
  logic data_unknown;
`endif

  // Compaction datapath: masked data, Galois shift with feedback, saturating count.
  always_comb begin
`ifdef GATE_RESPONSE_MISR_XMASK_EN
    data         = resp & ~resp_mask;
    // Reduction XOR goes X whenever any unmasked bit is X or Z.
    data_unknown = ((^data) === 1'bx);
`else
    data         = resp;
`endif
    accept    = resp_valid && resp_ready;
    last_beat = (cnt_q == LAST_BEAT);
    sig_next  = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ data;
    cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  end

  // Status outputs decoded from the registered state only.
  always_comb begin
    resp_ready = (state == ST_RUN);
    busy       = (state == ST_RUN);
    done       = (state == ST_DONE);
    pass       = pass_q;
    signature  = sig_q;
    beat_count = cnt_q;
    fsm_state  = state;
  end

  // Run-control FSM and MISR state; abort outranks start and beat acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      sig_q  <= SEED;
      cnt_q  <= 16'd0;
      pass_q <= 1'b0;
    end else if (abort) begin
      // Signature and count are left as-is so a cancelled run can be inspected.
      state  <= ST_IDLE;
      pass_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state  <= ST_RUN;
            sig_q  <= SEED;
            cnt_q  <= 16'd0;
            pass_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            sig_q <= sig_next;
            cnt_q <= cnt_inc;
            if (last_beat) begin
              state  <= ST_DONE;
              pass_q <= (sig_next == golden);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef GATE_RESPONSE_MISR_XMASK_EN
  // Sticky unknown detector: cleared by reset or a new run, set by an X/Z beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_seen_q <= 1'b0;
    end else if (!abort) begin
      if ((state != ST_RUN) && start) begin
        x_seen_q <= 1'b0;
      end else if (accept && data_unknown) begin
        x_seen_q <= 1'b1;
      end
    end
  end

  assign x_seen = x_seen_q;
`endif

endmodule
